slow_tick_pacer: RTL and testbench
==================================

# slow_tick_pacer

Consumes the divided slow clock produced by the design's clock divider (e.g. the 25 Hz square wave) inside the fast `i_clk` domain. It synchronizes the slow clock, turns each rising edge into a one-cycle tick, and paces a decelerating sequence of single-cycle step pulses. The step pulses drive the lab's roll-and-slow-down display/counter logic. It replaces the use of the divided signal as a clock with a clean clock enable.

## Interface
- `N_STAGES`, default 8: number of deceleration stages.
- `STEPS_PER_STAGE`, default 4: step pulses emitted per stage.
- `INIT_INTERVAL`, default 1: ticks between steps in stage 0. Must be ≥1.
- `INTERVAL_INC`, default 1: interval added at each stage boundary.
- `i_clk`, input, 1: system clock; the only clock.
- `i_rst`, input, 1: reset, synchronous, active-high.
- `i_slow_clk`, input, 1: divided square wave. Asynchronous to `i_clk` for synchronization purposes.
- `i_start`, input, 1: level sampled each cycle. High in any state (re)starts the sequence.
- `o_tick`, output, 1: one-cycle pulse per synchronized rising edge of `i_slow_clk`. Combinational from the synchronizer flops.
- `o_step`, output, 1: registered one-cycle step pulse.
- `o_busy`, output, 1: registered; high while the sequence runs.
- `o_done`, output, 1: registered one-cycle pulse coincident with the final `o_step`.

## Operation
- Synchronizer chain `s1 → s2 → s3`, all cleared by `i_rst`.
  - `o_tick = s2 & ~s3`.
  - An input already high at reset release yields exactly one tick.
- FSM states:
  - **IDLE** (reset state).
  - **RUN**.
- Registers:
  - `tick_cnt`, `interval`: width `$clog2(INIT_INTERVAL+(N_STAGES-1)*INTERVAL_INC+1)`.
  - `step_cnt`: width `$clog2(STEPS_PER_STAGE)`, minimum 1.
  - `stage`: width `$clog2(N_STAGES)`, minimum 1.
- **IDLE**, `i_start`=1 → RUN:
  - `interval=INIT_INTERVAL`.
  - `tick_cnt=step_cnt=stage=0`.
  - `o_busy`=1 from the next cycle.
- **RUN**, `i_start`=1: same reload as above. The restart wins over a simultaneous tick; that tick is dropped.
- **RUN**, tick with `tick_cnt==interval-1` → step:
  - `o_step`=1 next cycle.
  - `tick_cnt=0`.
  - If `step_cnt==STEPS_PER_STAGE-1`: `step_cnt=0`.
    - If `stage==N_STAGES-1`: last step, `o_done`=1 and `o_busy`=0 in the same cycle as the final `o_step`, FSM → IDLE.
    - Otherwise: `stage++`, `interval+=INTERVAL_INC`.
  - Otherwise: `step_cnt++`.
- **RUN**, other tick: `tick_cnt++`.
- **IDLE**: ticks are ignored. `o_tick` still pulses.
- Interval arithmetic never wraps, because the width covers the maximum interval.
- Total steps = `N_STAGES*STEPS_PER_STAGE`.
- Total ticks = Σ over s of `STEPS_PER_STAGE*(INIT_INTERVAL+s*INTERVAL_INC)`.

## Timing
- Reset values:
  - `o_step`=0, `o_busy`=0, `o_done`=0.
  - `o_tick`=0, since s2=s3=0.
  - FSM in IDLE, all counters 0.
- `i_rst` mid-sequence: the next cycle is IDLE with all outputs 0. No step or done pulse is emitted.
- Edge latency: `i_slow_clk` first sampled high at edge k:
  - s1=1 after edge k.
  - `o_tick` high during the cycle after edge k+1.
  - `o_step` (if due) high during the cycle after edge k+2.
- `i_start` at edge k → `o_busy`=1 after edge k. The first tick counted is any `o_tick` in a cycle after edge k.
- `o_step` and `o_done` are each exactly one `i_clk` cycle wide. Steps are never back-to-back, because ticks are ≥2 cycles apart.
- `i_slow_clk` high and low phases must each be ≥2 `i_clk` cycles. Shorter pulses may be missed; this is not detected.

## Structure
- Package `slow_tick_pkg`:
  - `typedef enum logic {S_IDLE, S_RUN} pacer_state_t`.
  - Width-helper localparams or functions for the counters.
- Sub-module `sync_edge_det`:
  - Ports: `i_clk`, `i_rst`, `i_async`, `o_rise`.
  - Contents: the 3-flop synchronizer plus rising-edge detect.
  - Instantiated once; reusable for the lab's key inputs.
- Top: FSM and counters in `always_comb` next-state logic plus one synchronous-reset `always_ff`.

## Test plan
1. **Reset:** hold `i_slow_clk`=0 and `i_rst`=1 for 3 cycles → all outputs 0, `o_busy`=0. Release, toggle `i_slow_clk` 4 times with `i_start`=0 → 4 `o_tick` pulses, no `o_step`.
2. **Full sequence:** params 2/2/1/1, `i_slow_clk` period 10 cycles, pulse `i_start` → `o_step` after ticks 1, 2, 4, 6. `o_done` coincides with the 4th step. `o_busy` falls the same cycle. Exactly 4 steps total.
3. **Latency:** `i_slow_clk` rises just before edge k while RUN with step due → `o_tick` in the cycle after edge k+1, `o_step` in the cycle after edge k+2.
4. **Restart:** `i_start` raised in the same cycle as a due tick mid-stage 1 → no `o_step` that cycle. Counters reload. The next step occurs after `INIT_INTERVAL` ticks.
5. **Reset mid-run:** assert `i_rst` during stage 1 → `o_busy`=0 the next cycle. No `o_done`. Subsequent ticks produce no steps until `i_start`.
6. **Defaults:** default params, run to completion → 32 `o_step` pulses, 8·4·1+4·(0+1+…+7)=144 ticks, and one `o_done`.

Source files
------------

// File: rtl/slow_tick_pacer_pkg.sv
// Shared types and width helpers for the slow tick pacer and its bench.
package slow_tick_pkg;

    typedef enum logic {S_IDLE, S_RUN} pacer_state_t;

    // $clog2 that never returns less than one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

    // Width that holds every interval value the sequence can reach.
    function automatic int interval_width(input int n_stages, input int init_interval,
                                          input int interval_inc);
        return clog2_min1(init_interval + (n_stages - 1) * interval_inc + 1);
    endfunction

endpackage

// File: rtl/slow_tick_pacer_if.sv
// Signal bundle between the pacer and whoever drives the slow clock / start.
// Handshake: none. i_start is a level sampled every i_clk cycle; o_tick,
// o_step and o_done are single-cycle pulses; o_busy is a level.
interface slow_tick_pacer_if;
    import slow_tick_pkg::*;

    logic         i_slow_clk;
    logic         i_start;
    logic         o_tick;
    logic         o_step;
    logic         o_busy;
    logic         o_done;
    pacer_state_t o_state;   // debug view of the FSM state

    modport master (
        output i_slow_clk, i_start,
        input  o_tick, o_step, o_busy, o_done, o_state
    );

    modport slave (
        input  i_slow_clk, i_start,
        output o_tick, o_step, o_busy, o_done, o_state
    );
endinterface

// File: rtl/sync_edge_det.sv
// Three-flop synchronizer for an asynchronous level plus rising-edge detect.
module sync_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise
);
    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Shift the asynchronous level through the synchronizer chain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // A level already high at reset release still produces one rise.
    assign o_rise = r_s2 & ~r_s3;
endmodule

// File: rtl/slow_tick_pacer.sv
// Turns a divided slow clock into ticks and paces a decelerating run of
// single-cycle step pulses as a clock enable for the display logic.
module slow_tick_pacer
    import slow_tick_pkg::*;
#(
    parameter int N_STAGES        = 8,
    parameter int STEPS_PER_STAGE = 4,
    parameter int INIT_INTERVAL   = 1,
    parameter int INTERVAL_INC    = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    slow_tick_pacer_if.slave  io_pacer
);
    localparam int IW = interval_width(N_STAGES, INIT_INTERVAL, INTERVAL_INC);
    localparam int SW = clog2_min1(STEPS_PER_STAGE);
    localparam int NW = clog2_min1(N_STAGES);

    localparam logic [IW-1:0] IV_INIT   = IW'(INIT_INTERVAL);
    localparam logic [IW-1:0] IV_INC    = IW'(INTERVAL_INC);
    localparam logic [IW-1:0] IV_ONE    = IW'(1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEPS_PER_STAGE - 1);
    localparam logic [SW-1:0] STEP_ONE  = SW'(1);
    localparam logic [NW-1:0] STG_LAST  = NW'(N_STAGES - 1);
    localparam logic [NW-1:0] STG_ONE   = NW'(1);

    pacer_state_t  r_state, w_state_nxt;
    logic [IW-1:0] r_tick_cnt, w_tick_cnt_nxt;
    logic [IW-1:0] r_interval, w_interval_nxt;
    logic [SW-1:0] r_step_cnt, w_step_cnt_nxt;
    logic [NW-1:0] r_stage, w_stage_nxt;
    logic          r_step, w_step_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          w_tick;

    sync_edge_det u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (io_pacer.i_slow_clk),
        .o_rise  (w_tick)
    );

    // Next-state logic: restart beats any tick in the same cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_tick_cnt_nxt = r_tick_cnt;
        w_interval_nxt = r_interval;
        w_step_cnt_nxt = r_step_cnt;
        w_stage_nxt    = r_stage;
        w_step_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        if (io_pacer.i_start) begin
            w_state_nxt    = S_RUN;
            w_tick_cnt_nxt = '0;
            w_interval_nxt = IV_INIT;
            w_step_cnt_nxt = '0;
            w_stage_nxt    = '0;
        end else if (r_state == S_RUN && w_tick) begin
            if (r_tick_cnt == r_interval - IV_ONE) begin
                w_step_nxt     = 1'b1;
                w_tick_cnt_nxt = '0;
                if (r_step_cnt == STEP_LAST) begin
                    w_step_cnt_nxt = '0;
                    if (r_stage == STG_LAST) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_stage_nxt    = r_stage + STG_ONE;
                        w_interval_nxt = r_interval + IV_INC;
                    end
                end else begin
                    w_step_cnt_nxt = r_step_cnt + STEP_ONE;
                end
            end else begin
                w_tick_cnt_nxt = r_tick_cnt + IV_ONE;
            end
        end
        w_busy_nxt = (w_state_nxt == S_RUN);
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_interval <= '0;
            r_step_cnt <= '0;
            r_stage    <= '0;
            r_step     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_interval <= w_interval_nxt;
            r_step_cnt <= w_step_cnt_nxt;
            r_stage    <= w_stage_nxt;
            r_step     <= w_step_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign io_pacer.o_tick  = w_tick;
    assign io_pacer.o_step  = r_step;
    assign io_pacer.o_busy  = r_busy;
    assign io_pacer.o_done  = r_done;
    assign io_pacer.o_state = r_state;
endmodule

// File: tb/tb_slow_tick_pacer.sv
// Directed bench: a small 2/2/1/1 pacer for sequence, latency, restart and
// reset cases, and a default-parameter pacer run to completion.
module tb_slow_tick_pacer;
    import slow_tick_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    slow_tick_pacer_if pa ();
    slow_tick_pacer_if pb ();

    slow_tick_pacer #(
        .N_STAGES(2), .STEPS_PER_STAGE(2), .INIT_INTERVAL(1), .INTERVAL_INC(1)
    ) u_dut_a (
        .i_clk    (clk),
        .i_rst    (rst),
        .io_pacer (pa)
    );

    slow_tick_pacer u_dut_b (
        .i_clk    (clk),
        .i_rst    (rst),
        .io_pacer (pb)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---------------- monitor (negedge, away from active edge) ----------------
    int ticks_a = 0, steps_a = 0, dones_a = 0, done_step_a = 0;
    int ticks_b = 0, steps_b = 0, dones_b = 0, done_tick_b = 0;
    logic [31:0] act_q[$];
    logic [31:0] busy_q[$];

    always @(negedge clk) begin
        if (pa.o_tick) ticks_a++;
        if (pa.o_step) begin
            steps_a++;
            act_q.push_back(32'(ticks_a));
            busy_q.push_back({31'd0, pa.o_busy});
        end
        if (pa.o_done) begin
            dones_a++;
            done_step_a = steps_a;
        end
        if (pb.o_tick) ticks_b++;
        if (pb.o_step) steps_b++;
        if (pb.o_done) begin
            dones_b++;
            done_tick_b = ticks_b;
        end
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic slow_periods_a(input int n);
        repeat (n) begin
            pa.i_slow_clk = 1'b1;
            cyc(5);
            pa.i_slow_clk = 1'b0;
            cyc(5);
        end
    endtask

    task automatic slow_periods_b(input int n);
        repeat (n) begin
            pb.i_slow_clk = 1'b1;
            cyc(5);
            pb.i_slow_clk = 1'b0;
            cyc(5);
        end
    endtask

    task automatic pulse_start_a();
        pa.i_start = 1'b1;
        cyc(1);
        pa.i_start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] exp_q[$];
    logic [31:0] exp_busy_q[$];
    int base_t, base_s, base_d, n_per;

    initial begin
        pa.i_slow_clk = 1'b0; pa.i_start = 1'b0;
        pb.i_slow_clk = 1'b0; pb.i_start = 1'b0;

        // 1. reset state, then free-running ticks while idle
        cyc(3);
        check("rst_tick_a", {31'd0, pa.o_tick}, 0);
        check("rst_step_a", {31'd0, pa.o_step}, 0);
        check("rst_busy_a", {31'd0, pa.o_busy}, 0);
        check("rst_done_a", {31'd0, pa.o_done}, 0);
        check("rst_state_a", {31'd0, pa.o_state}, {31'd0, S_IDLE});
        check("rst_busy_b", {31'd0, pb.o_busy}, 0);
        rst = 1'b0;
        base_t = ticks_a; base_s = steps_a;
        slow_periods_a(4);
        check("idle_ticks", 32'(ticks_a - base_t), 4);
        check("idle_steps", 32'(steps_a - base_s), 0);
        check("idle_busy", {31'd0, pa.o_busy}, 0);

        // 2. full sequence: steps after ticks 1,2,4,6
        act_q.delete(); busy_q.delete();
        base_t = ticks_a; base_s = steps_a; base_d = dones_a;
        pulse_start_a();
        check("seq_busy_start", {31'd0, pa.o_busy}, 1);
        exp_q = '{32'(base_t + 1), 32'(base_t + 2), 32'(base_t + 4), 32'(base_t + 6)};
        exp_busy_q = '{32'd1, 32'd1, 32'd1, 32'd0};
        slow_periods_a(7);
        check("seq_step_count", 32'(act_q.size()), 4);
        while (exp_q.size() > 0 && act_q.size() > 0)
            check("seq_step_tick", act_q.pop_front(), exp_q.pop_front());
        while (exp_busy_q.size() > 0 && busy_q.size() > 0)
            check("seq_busy_at_step", busy_q.pop_front(), exp_busy_q.pop_front());
        check("seq_done_count", 32'(dones_a - base_d), 1);
        check("seq_done_on_step4", 32'(done_step_a - base_s), 4);
        check("seq_busy_end", {31'd0, pa.o_busy}, 0);

        // 3. latency: first step due on the first tick
        pulse_start_a();
        pa.i_slow_clk = 1'b1;          // sampled at edge k
        cyc(1);
        check("lat_tick_k", {31'd0, pa.o_tick}, 0);
        cyc(1);
        check("lat_tick_k1", {31'd0, pa.o_tick}, 1);
        check("lat_step_k1", {31'd0, pa.o_step}, 0);
        cyc(1);
        check("lat_tick_k2", {31'd0, pa.o_tick}, 0);
        check("lat_step_k2", {31'd0, pa.o_step}, 1);
        cyc(1);
        check("lat_step_k3", {31'd0, pa.o_step}, 0);
        cyc(2);
        pa.i_slow_clk = 1'b0;
        cyc(5);

        // 4. restart on a due tick in stage 1
        slow_periods_a(2);             // tick2 steps into stage 1, tick3 counts
        base_s = steps_a;
        pa.i_slow_clk = 1'b1;
        cyc(1);
        cyc(1);
        check("rs_tick", {31'd0, pa.o_tick}, 1);
        pa.i_start = 1'b1;
        cyc(1);
        pa.i_start = 1'b0;
        check("rs_no_step", {31'd0, pa.o_step}, 0);
        check("rs_busy", {31'd0, pa.o_busy}, 1);
        cyc(3);
        pa.i_slow_clk = 1'b0;
        cyc(5);
        check("rs_no_step_total", 32'(steps_a - base_s), 0);
        slow_periods_a(1);
        check("rs_step_after_init", 32'(steps_a - base_s), 1);

        // 5. reset in stage 1
        slow_periods_a(2);             // tick2 -> stage 1, tick3 counts
        check("mid_busy", {31'd0, pa.o_busy}, 1);
        base_d = dones_a;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("mid_busy_rst", {31'd0, pa.o_busy}, 0);
        check("mid_step_rst", {31'd0, pa.o_step}, 0);
        check("mid_done_rst", {31'd0, pa.o_done}, 0);
        base_t = ticks_a; base_s = steps_a;
        slow_periods_a(4);
        check("post_rst_ticks", 32'(ticks_a - base_t), 4);
        check("post_rst_steps", 32'(steps_a - base_s), 0);
        check("post_rst_done", 32'(dones_a - base_d), 0);

        // 6. default parameters to completion
        base_t = ticks_b; base_s = steps_b; base_d = dones_b;
        pb.i_start = 1'b1;
        cyc(1);
        pb.i_start = 1'b0;
        check("def_busy_start", {31'd0, pb.o_busy}, 1);
        n_per = 0;
        while (dones_b == base_d && n_per < 200) begin
            slow_periods_b(1);
            n_per++;
        end
        if (n_per >= 200) check("def_timeout", 32'(n_per), 144);
        check("def_steps", 32'(steps_b - base_s), 32);
        check("def_done_tick", 32'(done_tick_b - base_t), 144);
        check("def_done_count", 32'(dones_b - base_d), 1);
        check("def_busy_end", {31'd0, pb.o_busy}, 0);
        base_s = steps_b;
        slow_periods_b(3);
        check("def_no_more_steps", 32'(steps_b - base_s), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
